csel_serial_subtractor: RTL



---
 rtl/csel_arith_pkg.sv | 22 ++
 rtl/csel_sub4.sv | 31 +++
 rtl/csel_serial_subtractor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/csel_arith_pkg.sv
// ---------------------------------------------------------------------------
// csel_arith_pkg
// Shared definitions for the borrow-select serial arithmetic blocks.
//   CHUNK_W      : width of one serial slice (4 bits)
//   state_t      : controller states IDLE / RUN / DONE
//   chunk_count  : number of CHUNK_W slices needed for a given operand width
// ---------------------------------------------------------------------------
package csel_arith_pkg;

    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int chunk_count(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/csel_sub4.sv
// ---------------------------------------------------------------------------
// csel_sub4
// Combinational 4-bit borrow-select subtractor slice.
// Both candidate differences (borrow-in 0 and borrow-in 1) are formed in
// parallel as a + ~b + 1 and a + ~b; borrow_in only drives the final mux.
// Ports:
//   a4         in  4  minuend slice
//   b4         in  4  subtrahend slice
//   borrow_in  in  1  borrow into this slice
//   d4         out 4  difference slice
//   borrow_out out 1  borrow out of this slice (inverse of the carry)
// ---------------------------------------------------------------------------
module csel_sub4 (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       borrow_in,
    output logic [3:0] d4,
    output logic       borrow_out
);

    logic [4:0] w_d0;
    logic [4:0] w_d1;

    assign w_d0 = {1'b0, a4} + {1'b0, ~b4} + 5'd1;
    assign w_d1 = {1'b0, a4} + {1'b0, ~b4};

    // A carry out of the two's-complement add means no borrow was needed.
    assign d4         = borrow_in ? w_d1[3:0] : w_d0[3:0];
    assign borrow_out = borrow_in ? ~w_d1[4]  : ~w_d0[4];

endmodule

// File: rtl/csel_serial_subtractor.sv
// ---------------------------------------------------------------------------
// csel_serial_subtractor
// Multi-cycle subtractor: diff = (a - b - bin) mod 2^WIDTH, one 4-bit chunk
// per clock, LSB chunk first, using a borrow-select slice (csel_sub4).
// The accept edge is edge 0; chunk k is processed on edge k+1, and done is
// high for the single cycle following the edge that processes the last chunk.
// A start in the DONE cycle is accepted, giving one result per N+1 cycles.
//
// Optional feature: define CSEL_SUB_OVERFLOW_EN to add the ovf output
// (signed two's-complement overflow of the subtraction).
//
// Parameters:
//   WIDTH  operand/result width, multiple of 4 and >= 4
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, accepted when busy=0
//   a      in   WIDTH  minuend (sampled on accept)
//   b      in   WIDTH  subtrahend (sampled on accept)
//   bin    in   1      borrow-in (sampled on accept)
//   busy   out  1      operation in progress
//   done   out  1      one-cycle result-valid pulse
//   diff   out  WIDTH  result, held until overwritten by the next operation
//   ovf    out  1      signed overflow (CSEL_SUB_OVERFLOW_EN only)
//   bout   out  1      final borrow-out, 1 when a < b + bin (unsigned)
// ---------------------------------------------------------------------------
module csel_serial_subtractor
    import csel_arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef CSEL_SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int N     = chunk_count(WIDTH);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_busy;
    logic               r_done;
`ifdef CSEL_SUB_OVERFLOW_EN
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_ovf;
`endif

    logic [CHUNK_W-1:0] w_d4;
    logic               w_borrow_out;
    logic               w_accept;

    // Operand registers shift right each chunk, so the active slice is
    // always the low nibble.
    csel_sub4 u_slice (
        .a4         (r_a[CHUNK_W-1:0]),
        .b4         (r_b[CHUNK_W-1:0]),
        .borrow_in  (r_borrow),
        .d4         (w_d4),
        .borrow_out (w_borrow_out)
    );

    // RUN ignores start; IDLE and DONE both accept.
    assign w_accept = start && (r_state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef CSEL_SUB_OVERFLOW_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            // diff is deliberately left alone; it is overwritten chunk by chunk.
            r_state  <= RUN;
            r_cnt    <= '0;
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
`ifdef CSEL_SUB_OVERFLOW_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
        end else begin
            case (r_state)
                RUN: begin
                    r_diff[r_cnt*CHUNK_W +: CHUNK_W] <= w_d4;
                    r_borrow <= w_borrow_out;
                    r_a      <= r_a >> CHUNK_W;
                    r_b      <= r_b >> CHUNK_W;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CHUNK) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bout  <= w_borrow_out;
`ifdef CSEL_SUB_OVERFLOW_EN
                        // w_d4[3] is the MSB of the final diff.
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_d4[CHUNK_W-1] != r_a_msb);
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef CSEL_SUB_OVERFLOW_EN
    assign ovf  = r_ovf;
`endif

endmodule
